// File: rtl/muxn_stream_if.sv
// Handshake bundle for muxn_stream: N producer streams in, one registered stream out.
// The master side drives producers and the consumer's ready; the slave side is the mux.
interface muxn_stream_if #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = 2
);
  logic            mode;
  logic [SELW-1:0] sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_ch;
  logic            out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/muxn_stream.sv
// N-channel registered stream multiplexer: fixed-select or round-robin grant
// feeding a single output register with full valid/ready backpressure.
module muxn_stream #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  muxn_stream_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_next;
  logic [W-1:0]    data_q;
  logic [SELW-1:0] ch_q;
  logic [SELW-1:0] ptr;

  logic            full;
  logic            load_en;
  logic            grant_valid;
  logic [SELW-1:0] grant;
  logic            transfer;
  logic [W-1:0]    grant_data;
  logic [N-1:0]    in_ready_c;
  logic [W-1:0]    ch_data [N];

  assign full    = (state == ST_FULL);
  assign load_en = !full || bus.out_ready;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign ch_data[g] = bus.in_data[g*W +: W];
  end

  // Round-robin starts one past the last winner so the previous winner is checked last.
  always_comb begin
    logic [SELW:0] cand;
    // NOTE: every output gets a default before any branch, otherwise paths that
    // skip an assignment infer latches.
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    if (!bus.mode) begin
      if (({1'b0, bus.sel} < (SELW+1)'(N)) && bus.in_valid[bus.sel]) begin
        grant_valid = 1'b1;
        grant       = bus.sel;
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        cand = {1'b0, ptr} + (SELW+1)'(i);
        if (cand >= (SELW+1)'(N)) cand = cand - (SELW+1)'(N);
        if (!grant_valid && bus.in_valid[cand[SELW-1:0]]) begin
          grant_valid = 1'b1;
          grant       = cand[SELW-1:0];
        end
      end
    end
  end

  assign grant_data = ch_data[grant];
  assign transfer   = load_en && grant_valid;

  // Ready is held low during reset so no producer believes a word was taken.
  always_comb begin
    in_ready_c = '0;
    if (rst_n && transfer) in_ready_c[grant] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (transfer) state_next = ST_FULL;
      ST_FULL:  if (bus.out_ready && !transfer) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, so a discarded word never reappears
      // on out_data after reset.
      state  <= ST_EMPTY;
      data_q <= '0;
      ch_q   <= '0;
      ptr    <= SELW'(N-1);
    end else begin
      state <= state_next;
      if (transfer) begin
        data_q <= grant_data;
        ch_q   <= grant;
        if (bus.mode) ptr <= grant;
      end
    end
  end

  assign bus.out_valid = full;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.in_ready  = in_ready_c;

  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (full && !bus.out_ready) |=> (full && $stable(data_q) && $stable(ch_q)));

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready_c));

endmodule

// File: tb/tb_muxn_stream.sv
// Bench for muxn_stream: a N=4/W=8 and a N=3/W=16 instance, directed cases plus
// random traffic against a cycle model feeding a scoreboard queue per instance.
module tb_muxn_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muxn_stream_if #(.N(4), .W(8),  .SELW(2)) a_if ();
  muxn_stream_if #(.N(3), .W(16), .SELW(2)) b_if ();

  muxn_stream #(.N(4), .W(8),  .SELW(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  muxn_stream #(.N(3), .W(16), .SELW(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [71:0] exp_t;   // {channel[7:0], data[63:0]}
  exp_t exp_a[$];
  exp_t exp_b[$];
  bit   ov_m  [2];
  int   ptr_m [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant(input int n, input bit mode, input int sel,
                                   input logic [15:0] v, input int ptr);
    if (!mode) return (sel < n && v[sel]) ? sel : -1;
    for (int i = 1; i <= n; i++) begin
      int c = (ptr + i) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Cycle model evaluated mid-cycle: checks ready/valid, pops on output handshake,
  // pushes the word the next edge must load.
  task automatic mon_step(input int k, input int n, input int w, input logic rstn,
                          input bit mode, input int sel, input logic [15:0] valid,
                          input logic [63:0] data, input bit oready,
                          input logic [15:0] iready, input logic ovalid,
                          input logic [63:0] odata, input int och);
    string p = (k == 0) ? "a" : "b";
    int    g;
    bit    le;
    exp_t  e;
    logic [63:0] mask;
    if (!rstn) begin
      ov_m[k]  = 1'b0;
      ptr_m[k] = n - 1;
      if (k == 0) exp_a.delete(); else exp_b.delete();
      check({p, ".reset_in_ready"}, 64'(iready), 64'd0);
      return;
    end
    g  = exp_grant(n, mode, sel, valid, ptr_m[k]);
    le = !ov_m[k] || oready;
    check({p, ".in_ready"}, 64'(iready), (le && g >= 0) ? (64'd1 << g) : 64'd0);
    check({p, ".out_valid"}, 64'(ovalid), 64'(ov_m[k]));
    if (ovalid === 1'b1 && oready) begin
      if ((k == 0 ? exp_a.size() : exp_b.size()) == 0) begin
        check({p, ".sb_unexpected_word"}, 64'd1, 64'd0);
      end else begin
        e = (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
        check({p, ".sb_ch"},   64'(och), 64'(e[71:64]));
        check({p, ".sb_data"}, odata,    e[63:0]);
      end
    end
    if (le) begin
      if (g >= 0) begin
        mask = (64'd1 << w) - 64'd1;
        e = {8'(g), (data >> (g * w)) & mask};
        if (k == 0) exp_a.push_back(e); else exp_b.push_back(e);
        ov_m[k] = 1'b1;
        if (mode) ptr_m[k] = g;
      end else begin
        ov_m[k] = 1'b0;
      end
    end
  endtask

  always @(negedge clk)
    mon_step(0, 4, 8, rst_n, a_if.mode, int'(a_if.sel), 16'(a_if.in_valid),
             64'(a_if.in_data), a_if.out_ready, 16'(a_if.in_ready), a_if.out_valid,
             64'(a_if.out_data), int'(a_if.out_ch));

  always @(negedge clk)
    mon_step(1, 3, 16, rst_n, b_if.mode, int'(b_if.sel), 16'(b_if.in_valid),
             64'(b_if.in_data), b_if.out_ready, 16'(b_if.in_ready), b_if.out_valid,
             64'(b_if.out_data), int'(b_if.out_ch));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.mode = 1'b0; a_if.sel = '0; a_if.in_valid = '0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    b_if.mode = 1'b0; b_if.sel = '0; b_if.in_valid = '0; b_if.in_data = '0; b_if.out_ready = 1'b0;
    step();
    check("a.reset_out_valid", 64'(a_if.out_valid), 64'd0);
    check("a.reset_out_data",  64'(a_if.out_data),  64'd0);
    step();
    rst_n = 1'b1;

    // Fixed select
    a_if.mode = 1'b0; a_if.sel = 2'd2; a_if.in_valid = 4'b1111;
    a_if.in_data = {8'h03, 8'hA5, 8'h01, 8'h00}; a_if.out_ready = 1'b1;
    #1 check("a.fix_in_ready", 64'(a_if.in_ready), 64'b0100);
    step();
    check("a.fix_out_valid", 64'(a_if.out_valid), 64'd1);
    check("a.fix_out_data",  64'(a_if.out_data),  64'hA5);
    check("a.fix_out_ch",    64'(a_if.out_ch),    64'd2);
    a_if.sel = 2'd3; a_if.in_valid = 4'b0111;
    #1 check("a.fix_nogrant_in_ready", 64'(a_if.in_ready), 64'd0);
    step();
    check("a.fix_nogrant_drop", 64'(a_if.out_valid), 64'd0);
    check("a.fix_nogrant_hold", 64'(a_if.out_data),  64'hA5);

    // Round-robin, all valid then sparse
    a_if.mode = 1'b1; a_if.in_valid = 4'b1111; a_if.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("a.rr_ch%0d", i),   64'(a_if.out_ch),   64'(i % 4));
      check($sformatf("a.rr_data%0d", i), 64'(a_if.out_data), 64'(8'h10 + i % 4));
    end
    a_if.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("a.rr_sparse%0d", i), 64'(a_if.out_ch), (i % 2 == 0) ? 64'd1 : 64'd3);
    end
    a_if.in_valid = '0;
    step();

    // Backpressure
    a_if.mode = 1'b0; a_if.sel = 2'd1; a_if.in_valid = 4'b0010; a_if.in_data = {8'h00, 8'h00, 8'h33, 8'h00};
    step();
    check("a.bp_load", 64'(a_if.out_data), 64'h33);
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_if.in_valid = 4'($urandom); a_if.in_data = $urandom; a_if.sel = 2'($urandom);
      #1 check("a.bp_in_ready", 64'(a_if.in_ready), 64'd0);
      step();
      check("a.bp_data",  64'(a_if.out_data),  64'h33);
      check("a.bp_ch",    64'(a_if.out_ch),    64'd1);
      check("a.bp_valid", 64'(a_if.out_valid), 64'd1);
    end
    a_if.out_ready = 1'b1; a_if.sel = 2'd2; a_if.in_valid = 4'b0100; a_if.in_data = {8'h00, 8'h77, 8'h00, 8'h00};
    #1 check("a.bp_release_ready", 64'(a_if.in_ready), 64'b0100);
    step();
    check("a.bp_reload_data", 64'(a_if.out_data), 64'h77);
    check("a.bp_reload_ch",   64'(a_if.out_ch),   64'd2);
    a_if.in_valid = '0;
    step();

    // Mode switch keeps the round-robin pointer
    a_if.mode = 1'b1; a_if.in_valid = 4'b0010; a_if.in_data = {8'h23, 8'h22, 8'h21, 8'h20};
    step();
    check("a.ms_rr_ch1", 64'(a_if.out_ch), 64'd1);
    a_if.mode = 1'b0; a_if.sel = 2'd0; a_if.in_valid = 4'b1111;
    step(); check("a.ms_fix0", 64'(a_if.out_ch), 64'd0);
    step(); check("a.ms_fix1", 64'(a_if.out_ch), 64'd0);
    a_if.mode = 1'b1;
    #1 check("a.ms_rr_ready", 64'(a_if.in_ready), 64'b0100);
    step();
    check("a.ms_rr_ch2", 64'(a_if.out_ch), 64'd2);
    a_if.in_valid = '0;
    step();

    // Reset mid-stream
    a_if.in_valid = 4'b1111; a_if.out_ready = 1'b0;
    step();
    check("a.rst_pre_valid", 64'(a_if.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("a.rst_valid", 64'(a_if.out_valid), 64'd0);
    check("a.rst_data",  64'(a_if.out_data),  64'd0);
    check("a.rst_ch",    64'(a_if.out_ch),    64'd0);
    check("a.rst_ready", 64'(a_if.in_ready),  64'd0);
    step();
    rst_n = 1'b1; a_if.out_ready = 1'b1;
    #1 check("a.rst_first_rr", 64'(a_if.in_ready), 64'b0001);
    step();
    check("a.rst_first_ch", 64'(a_if.out_ch), 64'd0);

    // Random traffic on the 4-channel instance
    for (int i = 0; i < 200; i++) begin
      a_if.mode = 1'($urandom); a_if.sel = 2'($urandom); a_if.in_valid = 4'($urandom);
      a_if.in_data = $urandom; a_if.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    a_if.in_valid = '0; a_if.out_ready = 1'b1;
    step(); step();
    check("a.sb_drained", 64'(exp_a.size()), 64'd0);

    // 3-channel instance: out-of-range select and wrap
    b_if.mode = 1'b0; b_if.sel = 2'd3; b_if.in_valid = 3'b111; b_if.out_ready = 1'b1;
    b_if.in_data = {16'h1002, 16'h1001, 16'h1000};
    #1 check("b.sel3_ready", 64'(b_if.in_ready), 64'd0);
    step();
    check("b.sel3_valid", 64'(b_if.out_valid), 64'd0);
    b_if.mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("b.rr_ch%0d", i),   64'(b_if.out_ch),   64'(i % 3));
      check($sformatf("b.rr_data%0d", i), 64'(b_if.out_data), 64'(16'h1000 + i % 3));
    end
    for (int i = 0; i < 300; i++) begin
      b_if.mode = 1'($urandom); b_if.sel = 2'($urandom); b_if.in_valid = 3'($urandom);
      b_if.in_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      b_if.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    b_if.in_valid = '0; b_if.out_ready = 1'b1;
    step(); step();
    check("b.sb_drained", 64'(exp_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muxn_stream.md
# muxn_stream

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking; the sequential successor to the team's 2:1 gate-level mux. It selects one of N input streams, either by fixed select or by round-robin arbitration, and registers the chosen word into a single output stage with full backpressure. It sits between multiple producers and one shared consumer (bus, FIFO, serializer).

## Interface
- N, 4, number of input channels (2..16)
- W, 8, data width per channel (1..64)
- SELW, 2, width of SEL/OUT_CH; N <= 2**SELW required
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- MODE  in  1  0 = fixed select via SEL, 1 = round-robin arbitration
- SEL  in  SELW  channel select, used only when MODE=0
- IN_VALID  in  N  per-channel valid
- IN_DATA  in  N*W  channel i on bits [i*W +: W]
- IN_READY  out  N  per-channel ready, one-hot or zero, combinational
- OUT_VALID  out  1  output register holds a word
- OUT_DATA  out  W  registered data
- OUT_CH  out  SELW  channel index of OUT_DATA
- OUT_READY  in  1  consumer accepts word

## Operation
- Output stage FSM: EMPTY (OUT_VALID=0) / FULL (OUT_VALID=1).
- LOAD_EN = !OUT_VALID | OUT_READY; the output register accepts a new word only when LOAD_EN=1.
- Grant, combinational from current inputs:
  - MODE=0: grant SEL if SEL < N and IN_VALID[SEL]=1; SEL >= N gives no grant.
  - MODE=1: search from channel PTR+1 upward, wrapping N-1 -> 0; first channel with IN_VALID=1 is granted, PTR itself checked last.
- IN_READY[g] = LOAD_EN & grant_valid for granted g; all other bits 0. Non-granted channels see IN_READY=0 and hold.
- Transfer on channel g when IN_VALID[g] & IN_READY[g]: OUT_DATA <= IN_DATA[g], OUT_CH <= g, OUT_VALID <= 1.
- LOAD_EN=1 with no grant: OUT_VALID <= 0; OUT_DATA/OUT_CH hold last values.
- EMPTY -> FULL on transfer. FULL -> EMPTY on OUT_READY with no transfer. FULL -> FULL on OUT_READY with transfer (back-to-back), or on !OUT_READY (hold).
- PTR (SELW bits) updates to g on every transfer in MODE=1 only; unchanged in MODE=0 and on idle cycles.
- MODE or SEL changes take effect on the grant in the same cycle; a word already in the output register is unaffected.

## Timing
- Reset (RST_N low, async): OUT_VALID=0, OUT_DATA=0, OUT_CH=0, PTR=N-1, so the first round-robin search starts at channel 0. IN_READY forced to 0 while RST_N=0.
- Reset mid-transfer discards the held word; no partial output.
- Latency: 1 cycle from transfer edge to OUT_VALID/OUT_DATA.
- Throughput: 1 word/cycle with OUT_READY held high.
- While OUT_VALID=1 and OUT_READY=0: OUT_DATA, OUT_CH, OUT_VALID stable; IN_READY all 0.
- OUT_VALID never deasserts without an OUT_READY cycle, except on reset.
- Round-robin fairness: with all N valid held high and OUT_READY=1, grants cycle 0,1,...,N-1,0 with no channel served twice within any N consecutive transfers.

## Test plan
- Reset: drive RST_N=0 mid-stream with OUT_VALID=1 -> OUT_VALID, OUT_DATA, OUT_CH go to 0 immediately; after release, first MODE=1 grant is channel 0.
- Fixed select: MODE=0, SEL=2, IN_VALID=4'b1111, IN_DATA ch2=8'hA5, OUT_READY=1 -> IN_READY=4'b0100; next cycle OUT_VALID=1, OUT_DATA=8'hA5, OUT_CH=2. SEL=3 with IN_VALID[3]=0 -> IN_READY=0, OUT_VALID drops after one cycle.
- Round-robin: MODE=1, all valid, data = 8'h10+i, OUT_READY=1 for 8 cycles -> OUT_CH sequence 0,1,2,3,0,1,2,3 with matching data; sparse IN_VALID=4'b1010 -> alternates 1,3.
- Backpressure: FULL with OUT_DATA=8'h33, hold OUT_READY=0 for 5 cycles while inputs change -> OUT_DATA=8'h33, OUT_CH and OUT_VALID stable, IN_READY=0; OUT_READY=1 -> same-cycle reload with next granted word.
- Mode switch: MODE=1 after grant of ch1 (PTR=1), switch to MODE=0, SEL=0 for two transfers, back to MODE=1 -> PTR still 1, next RR grant ch2.
- Parameter sweep: N=3, W=16, SELW=2, SEL=3 -> never granted; RR wraps 2 -> 0; random traffic scoreboard checks every accepted word appears once, in order per channel, with correct OUT_CH.
